shared_and_arbiter: RTL and testbench
=====================================

SHARED_AND_ARBITER -- requirements
Module: shared_and_arbiter

Interface
REQ-001 Parameters SHALL be: NREQ, default 4, number of requesters (2..8); W, default 2, operand/result width.
REQ-002 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port req_valid  input  NREQ  request valid, bit i = requester i.
REQ-005 Port req_ready  output  NREQ  request accept, at most one bit high.
REQ-006 Ports req_a, req_b, req_c, req_d  input  NREQ*W  operands; requester i at bits [i*W +: W].
REQ-007 Port rsp_valid  output  NREQ  response valid, at most one bit high.
REQ-008 Port rsp_data  output  W  response result, shared by all requesters.
REQ-009 Port rsp_ready  input  NREQ  response accept, bit i = requester i.
REQ-010 Port grant_id  output  clog2(NREQ)  index of the requester currently owning the resource.
REQ-011 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 The block SHALL time-share one 4-operand bitwise AND unit (result = a & b & c & d) among NREQ requesters.
REQ-013 The FSM SHALL have states IDLE, EXEC and RESP, encoded as a shared enum.
REQ-014 In IDLE with any req_valid high, the grant g SHALL be the first valid index found searching upward from rr_ptr with wrap-around.
REQ-015 In IDLE, req_ready[g] SHALL be high combinationally in the same cycle, and IDLE SHALL transition to EXEC with req_a..req_d[g] captured into operand registers and g into grant_id.
REQ-016 In IDLE with no req_valid, the state, rr_ptr and all outputs SHALL hold.
REQ-017 EXEC SHALL last exactly one cycle, register the AND of the captured operands into the result register, and transition to RESP.
REQ-018 In RESP, rsp_valid[grant_id] SHALL be high and rsp_data SHALL equal the result register.
REQ-019 In RESP, when rsp_ready[grant_id] is high, the block SHALL set rr_ptr = (grant_id+1) mod NREQ and return to IDLE.
REQ-020 While in RESP with rsp_ready[grant_id] low, the block SHALL hold rsp_valid, rsp_data and grant_id stable indefinitely.
REQ-021 rsp_ready bits other than rsp_ready[grant_id] SHALL be ignored.
REQ-022 req_ready SHALL be all-zero in EXEC and RESP, so new requests wait and are never lost or duplicated.
REQ-023 Latency SHALL be: request accepted at cycle T, rsp_valid high at T+2; with rsp_ready tied high, peak throughput SHALL be one transaction per 3 cycles.
REQ-024 A req_valid deasserted before its grant SHALL cause no transaction, and changes to the operands after acceptance SHALL not affect the result.
REQ-025 The rr_ptr wrap from NREQ-1 to 0 SHALL give requester 0 priority next.
REQ-026 With all requesters continuously valid, the grant order SHALL be 0,1,...,NREQ-1,0,..., so no requester waits more than NREQ-1 transactions.

Reset
REQ-027 On rst_n low, the block SHALL asynchronously force: state IDLE; rr_ptr 0; grant_id 0; operand and result registers 0; req_ready, rsp_valid and rsp_data 0; busy 0.
REQ-028 A reset asserted mid-transaction (EXEC or RESP) SHALL discard that transaction with no response issued.
REQ-029 The first grant after reset release SHALL follow REQ-014 with rr_ptr = 0.

Structure
REQ-030 A shared package shared_and_pkg SHALL hold the FSM state enum and the default NREQ/W constants.
REQ-031 The AND unit SHALL be a separate sub-module bus_and4 (inputs A, B, C, D and output Q, each W bits, purely combinational), instantiated exactly once.

Verification (NREQ=4, W=2)
REQ-032 Single request: req_valid=0001 with a=11, b=11, c=10, d=11 -> req_ready=0001 at T, rsp_valid=0001 and rsp_data=10 at T+2.
REQ-033 All valid, rsp_ready=1111 -> grant_id sequence 0,1,2,3,0, one grant per 3 cycles.
REQ-034 rr_ptr=3, then req_valid=1001 -> grant 3, then grant 0 (wrap-around).
REQ-035 rsp_ready low for 5 cycles in RESP -> rsp_valid/rsp_data stable, req_ready=0000 throughout, then release completes the transaction.
REQ-036 rst_n pulsed low in EXEC -> all outputs 0 immediately; no rsp_valid afterwards; next request is granted from rr_ptr 0.
REQ-037 Operands changed in the cycle after acceptance (a=00) -> rsp_data still reflects the captured values.

Source files
------------

// File: rtl/shared_and_pkg.sv
// -----------------------------------------------------------------------------
// shared_and_pkg
//   Definitions shared by the time-shared AND arbiter and its sub-module.
//   - state_t  : the arbiter FSM states (IDLE -> EXEC -> RESP -> IDLE).
//   - NREQ_DEF : default number of requesters.
//   - W_DEF    : default operand/result width.
// -----------------------------------------------------------------------------
package shared_and_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // waiting for a request; arbitration is live
        EXEC = 2'd1,   // captured operands are being combined
        RESP = 2'd2    // result presented to the granted requester
    } state_t;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 2;

endpackage : shared_and_pkg

// File: rtl/shared_and_arbiter_bus_and4.sv
// -----------------------------------------------------------------------------
// bus_and4
//   Purely combinational 4-input bitwise AND over W-bit buses. This is the
//   single execution resource that the arbiter time-shares.
//
//   Ports
//     A, B, C, D : in  [W-1:0]  operands
//     Q          : out [W-1:0]  A & B & C & D
// -----------------------------------------------------------------------------
module bus_and4 #(
    parameter int W = 2
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [W-1:0] C,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q
);

    assign Q = A & B & C & D;

endmodule : bus_and4

// File: rtl/shared_and_arbiter.sv
// -----------------------------------------------------------------------------
// shared_and_arbiter
//   Round-robin arbiter that time-shares one 4-operand AND unit among NREQ
//   requesters. A transaction is: accept (IDLE) -> compute (EXEC) -> respond
//   (RESP, held until the owner accepts). Requests are only accepted in IDLE.
//
//   Ports
//     clk        : in   clock, all state updates on the rising edge
//     rst_n      : in   asynchronous active-low reset
//     req_valid  : in   [NREQ]    request valid, bit i = requester i
//     req_ready  : out  [NREQ]    request accept (one-hot or zero)
//     req_a..d   : in   [NREQ*W]  operands, requester i at [i*W +: W]
//     rsp_valid  : out  [NREQ]    response valid (one-hot or zero)
//     rsp_data   : out  [W]       response result, shared by all requesters
//     rsp_ready  : in   [NREQ]    response accept, only the owner's bit counts
//     grant_id   : out  [clog2(NREQ)] current owner of the AND unit
//     busy       : out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module shared_and_arbiter
    import shared_and_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*W-1:0]        req_a,
    input  logic [NREQ*W-1:0]        req_b,
    input  logic [NREQ*W-1:0]        req_c,
    input  logic [NREQ*W-1:0]        req_d,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [W-1:0]             rsp_data,
    input  logic [NREQ-1:0]          rsp_ready,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy
);

    localparam int GW = $clog2(NREQ);

    state_t          state_q, state_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    c_q, c_d;
    logic [W-1:0]    d_q, d_d;
    logic [W-1:0]    result_q, result_d;
    logic [W-1:0]    and_y;

    logic [GW-1:0]   grant_sel;
    logic            grant_found;

    // -------------------------------------------------------------------------
    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    // rr_ptr always points one past the last served requester, so with every
    // requester valid the grant order walks 0,1,...,NREQ-1,0,...
    // -------------------------------------------------------------------------
    always_comb begin
        int unsigned idx;
        grant_sel   = '0;
        grant_found = 1'b0;
        idx         = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_ptr_q) + i) % NREQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_sel   = idx[GW-1:0];
            end
        end
    end

    // -------------------------------------------------------------------------
    // The one shared AND unit, fed only from the captured operand registers so
    // that operand changes after acceptance cannot reach the result.
    // -------------------------------------------------------------------------
    bus_and4 #(
        .W (W)
    ) u_and (
        .A (a_q),
        .B (b_q),
        .C (c_q),
        .D (d_q),
        .Q (and_y)
    );

    // -------------------------------------------------------------------------
    // FSM next-state and request handshake
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        d_d       = d_q;
        result_d  = result_q;
        req_ready = '0;

        unique case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_sel] = 1'b1;
                    grant_d              = grant_sel;
                    a_d                  = req_a[grant_sel*W +: W];
                    b_d                  = req_b[grant_sel*W +: W];
                    c_d                  = req_c[grant_sel*W +: W];
                    d_d                  = req_d[grant_sel*W +: W];
                    state_d              = EXEC;
                end
            end
            EXEC: begin
                result_d = and_y;
                state_d  = RESP;
            end
            RESP: begin
                // Only the owner's rsp_ready can complete the transaction.
                if (rsp_ready[grant_q]) begin
                    if (int'(grant_q) == NREQ - 1) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = grant_q + 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Response outputs are decoded from registered state, so they stay stable
    // for as long as RESP is held and drop to zero on reset.
    // -------------------------------------------------------------------------
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (state_q == RESP) begin
            rsp_valid[grant_q] = 1'b1;
            rsp_data           = result_q;
        end
    end

    assign busy     = (state_q != IDLE);
    assign grant_id = grant_q;

    // -------------------------------------------------------------------------
    // State registers. Reset clears everything, which also discards any
    // transaction that was in flight.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            d_q      <= d_d;
            result_q <= result_d;
        end
    end

endmodule : shared_and_arbiter

// File: tb/tb_shared_and_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shared_and_arbiter
//   Directed-vector bench for shared_and_arbiter with NREQ=4, W=2. Inputs are
//   driven 1 time unit after the rising edge, outputs are sampled on the
//   falling edge.
// -----------------------------------------------------------------------------
module tb_shared_and_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a, req_b, req_c, req_d;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_data;
    logic [NREQ-1:0]   rsp_ready;
    logic [1:0]        grant_id;
    logic              busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shared_and_arbiter #(
        .NREQ (NREQ),
        .W    (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .req_d     (req_d),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    task automatic set_ops(input int i, input logic [1:0] a, input logic [1:0] b,
                           input logic [1:0] c, input logic [1:0] d);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_c[i*W +: W] = c;
        req_d[i*W +: W] = d;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_a     = '0;
        req_b     = '0;
        req_c     = '0;
        req_d     = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_req_ready got %b want 0000", req_ready);
        end
        checks++;
        if (rsp_valid !== 4'b0000 || rsp_data !== 2'b00) begin
            errors++; $display("FAIL reset_rsp got %b/%b want 0000/00", rsp_valid, rsp_data);
        end
        checks++;
        if (grant_id !== 2'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_grant_busy got %0d/%b want 0/0", grant_id, busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        set_ops(0, 2'b11, 2'b11, 2'b10, 2'b11);
        req_valid = 4'b0001;
        rsp_ready = 4'b0000;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001 || busy !== 1'b0) begin
            errors++; $display("FAIL single_accept got %b/%b want 0001/0", req_ready, busy);
        end
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || rsp_valid !== 4'b0000 || req_ready !== 4'b0000 || grant_id !== 2'd0) begin
            errors++; $display("FAIL single_exec got busy=%b rsp_valid=%b req_ready=%b grant=%0d want 1/0000/0000/0",
                               busy, rsp_valid, req_ready, grant_id);
        end
        @(posedge clk); #1;
        rsp_ready = 4'b0001;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_data !== 2'b10) begin
            errors++; $display("FAIL single_resp got %b/%b want 0001/10", rsp_valid, rsp_data);
        end
        @(posedge clk); #1;
        rsp_ready = 4'b0000;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin
            errors++; $display("FAIL single_done got busy=%b rsp_valid=%b want 0/0000", busy, rsp_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_oh;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_ops(i, 2'b11, 2'b11, 2'b11, 2'b11);
        req_valid = 4'b1111;
        rsp_ready = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_oh = 4'b0001 << (k % 4);
            @(negedge clk);
            checks++;
            if (req_ready !== exp_oh) begin
                errors++; $display("FAIL rr_accept_%0d got %b want %b", k, req_ready, exp_oh);
            end
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (grant_id !== 2'(k % 4) || req_ready !== 4'b0000) begin
                errors++; $display("FAIL rr_grant_%0d got %0d/%b want %0d/0000", k, grant_id, req_ready, k % 4);
            end
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (rsp_valid !== exp_oh || rsp_data !== 2'b11) begin
                errors++; $display("FAIL rr_resp_%0d got %b/%b want %b/11", k, rsp_valid, rsp_data, exp_oh);
            end
            @(posedge clk); #1;
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_wrap;
        // Serve requester 2 alone so the pointer lands on 3.
        set_ops(2, 2'b01, 2'b11, 2'b11, 2'b11);
        req_valid = 4'b0100;
        rsp_ready = 4'b1111;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("FAIL wrap_setup got %b want 0100", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 4'b1001;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++; $display("FAIL wrap_first got %b want 1000", req_ready);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL wrap_second got %b want 0001", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (grant_id !== 2'd0) begin
            errors++; $display("FAIL wrap_grant got %0d want 0", grant_id);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        // Pointer is at 1; other rsp_ready bits are high and must be ignored.
        set_ops(1, 2'b01, 2'b11, 2'b01, 2'b11);
        req_valid = 4'b1111;
        rsp_ready = 4'b1101;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL bp_accept got %b want 0010", req_ready);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 4'b0010 || rsp_data !== 2'b01 || req_ready !== 4'b0000 || grant_id !== 2'd1) begin
                errors++; $display("FAIL bp_hold_%0d got rsp_valid=%b data=%b req_ready=%b grant=%0d want 0010/01/0000/1",
                                   k, rsp_valid, rsp_data, req_ready, grant_id);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 4'b0010;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0010) begin
            errors++; $display("FAIL bp_release got %b want 0010", rsp_valid);
        end
        @(posedge clk); #1;
        req_valid = 4'b0000;
        rsp_ready = 4'b0000;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin
            errors++; $display("FAIL bp_done got busy=%b rsp_valid=%b want 0/0000", busy, rsp_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        // Pointer is at 2; only requester 3 asks.
        set_ops(3, 2'b11, 2'b11, 2'b11, 2'b11);
        req_valid = 4'b1000;
        rsp_ready = 4'b1111;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++; $display("FAIL rmid_accept got %b want 1000", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || grant_id !== 2'd3) begin
            errors++; $display("FAIL rmid_exec got busy=%b grant=%0d want 1/3", busy, grant_id);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000 || rsp_data !== 2'b00 ||
            busy !== 1'b0 || grant_id !== 2'd0) begin
            errors++; $display("FAIL rmid_async got req_ready=%b rsp_valid=%b data=%b busy=%b grant=%0d want all zero",
                               req_ready, rsp_valid, rsp_data, busy, grant_id);
        end
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
                errors++; $display("FAIL rmid_quiet_%0d got rsp_valid=%b busy=%b want 0000/0", k, rsp_valid, busy);
            end
        end
        @(posedge clk); #1;
        req_valid = 4'b1010;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL rmid_regrant got %b want 0010", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0010 || rsp_data !== 2'b01) begin
            errors++; $display("FAIL rmid_resp got %b/%b want 0010/01", rsp_valid, rsp_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_operand_change;
        // Pointer is at 2.
        set_ops(2, 2'b11, 2'b11, 2'b11, 2'b01);
        req_valid = 4'b0100;
        rsp_ready = 4'b0100;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("FAIL opchg_accept got %b want 0100", req_ready);
        end
        @(posedge clk); #1;
        req_a[2*W +: W] = 2'b00;
        req_valid = 4'b0000;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0100 || rsp_data !== 2'b01) begin
            errors++; $display("FAIL opchg_resp got %b/%b want 0100/01", rsp_valid, rsp_data);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL opchg_done got busy=%b want 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_operand_change();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_shared_and_arbiter
